btn_debounce: RTL



---
 rtl/btn_debounce.sv | 79 +++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioning: two-flop synchronizer and a per-button stability
// counter, plus press pulses and a registered one-hot "last pressed" selection.
module btn_debounce #(
  parameter int NB_BUTTONS = 4,
  parameter int NB_DEB     = 20,
  parameter int DEB_COUNT  = 1000000
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_btn,
  output logic [NB_BUTTONS-1:0] o_btn_level,
  output logic [NB_BUTTONS-1:0] o_btn_pulse,
  output logic [NB_BUTTONS-1:0] o_btn_sel,
  output logic                  o_valid
);

  localparam logic [NB_DEB-1:0]     CNT_MAX = NB_DEB'(DEB_COUNT - 1);
  localparam logic [NB_BUTTONS-1:0] SEL_RST = {{(NB_BUTTONS-1){1'b0}}, 1'b1};

  logic [NB_BUTTONS-1:0] s1_q, s2_q;
  logic [NB_BUTTONS-1:0] level_q, level_d;
  logic [NB_BUTTONS-1:0] pulse_q, pulse_d;
  logic [NB_BUTTONS-1:0] sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [NB_DEB-1:0]     cnt_q [NB_BUTTONS];
  logic [NB_DEB-1:0]     cnt_d [NB_BUTTONS];
  logic [NB_BUTTONS-1:0] lowest_pulse;

  // A disagreement must survive DEB_COUNT consecutive edges; any agreement clears the count.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < NB_BUTTONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s2_q[i];
        pulse_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Two's-complement trick isolates the lowest set pulse bit.
  always_comb begin
    lowest_pulse = pulse_q & (~pulse_q + 1'b1);
    valid_d      = |pulse_q;
    sel_d        = valid_d ? lowest_pulse : sel_q;
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      sel_q   <= SEL_RST;
      valid_q <= 1'b0;
      for (int i = 0; i < NB_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= i_btn;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      for (int i = 0; i < NB_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign o_btn_level = level_q;
  assign o_btn_pulse = pulse_q;
  assign o_btn_sel   = sel_q;
  assign o_valid     = valid_q;

endmodule
